// File: rtl/store_merge_unit_if.sv
// store_merge_unit_if: store request and word-wide data memory port bundle
interface store_merge_unit_if #(parameter int ADDR_WIDTH = 32);
    logic                  req_valid;
    logic                  req_ready;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [31:0]           req_data;
    logic [1:0]            StoreOp;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_rd_en;
    logic [31:0]           mem_rdata;
    logic                  mem_wr_en;
    logic [31:0]           mem_wdata;
    logic                  done;
    logic                  err;
    modport master (
        output req_valid, req_addr, req_data, StoreOp, mem_rdata,
        input  req_ready, mem_addr, mem_rd_en, mem_wr_en, mem_wdata, done, err
    );
    modport slave (
        input  req_valid, req_addr, req_data, StoreOp, mem_rdata,
        output req_ready, mem_addr, mem_rd_en, mem_wr_en, mem_wdata, done, err
    );
endinterface

// File: rtl/store_merge_unit.sv
// store_merge_unit: byte/half/word stores to a word-only memory via read-modify-write; STORE_MISALIGN_CHECK_EN faults odd-address halfword stores
module store_merge_unit #(
    parameter int ADDR_WIDTH = 32
) (
    input logic             Clk,
    input logic             Reset,
    store_merge_unit_if.slave bus
);
    typedef enum logic [2:0] {IDLE, READ, MERGE, WRITE, FAULT} state_t;
    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           word_q;
    logic                  byte_q;
    logic                  fault_req;
    logic [31:0]           mask;
    logic [31:0]           merged;
`ifdef STORE_MISALIGN_CHECK_EN
    assign fault_req = bus.StoreOp == 2'b11 || (bus.StoreOp == 2'b00 && bus.req_addr[0]);
`else
    assign fault_req = bus.StoreOp == 2'b11;
`endif
    assign mask   = byte_q ? 32'h0000_00FF << {addr_q[1:0], 3'b000} : 32'h0000_FFFF << {addr_q[1], 4'b0000};
    assign merged = (bus.mem_rdata & ~mask) | ((byte_q ? {4{word_q[7:0]}} : {2{word_q[15:0]}}) & mask);
    // state register
    always_ff @(posedge Clk) begin
        if (Reset) state <= IDLE;
        else       state <= state_nxt;
    end
    // latch the accepted request; word_q later holds the merged word for sub-word stores
    always_ff @(posedge Clk) begin
        if (Reset) begin
            addr_q <= '0;
            word_q <= '0;
            byte_q <= 1'b0;
        end else if (state == IDLE && bus.req_valid) begin
            addr_q <= bus.req_addr;
            word_q <= bus.req_data;
            byte_q <= bus.StoreOp == 2'b01;
        end else if (state == MERGE) begin
            word_q <= merged;
        end
    end
    // next state and outputs; everything is forced low while Reset is high
    always_comb begin
        state_nxt     = state;
        bus.req_ready = 1'b0;
        bus.mem_rd_en = 1'b0;
        bus.mem_wr_en = 1'b0;
        bus.mem_wdata = '0;
        bus.done      = 1'b0;
        bus.err       = 1'b0;
        bus.mem_addr  = state == IDLE ? '0 : {addr_q[ADDR_WIDTH-1:2], 2'b00};
        case (state)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid)
                    state_nxt = fault_req ? FAULT : bus.StoreOp == 2'b10 ? WRITE : READ;
            end
            READ: begin
                bus.mem_rd_en = 1'b1;
                state_nxt     = MERGE;
            end
            MERGE: state_nxt = WRITE;
            WRITE: begin
                bus.mem_wr_en = 1'b1;
                bus.mem_wdata = word_q;
                bus.done      = 1'b1;
                state_nxt     = IDLE;
            end
            FAULT: begin
                bus.done  = 1'b1;
                bus.err   = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (Reset) begin
            bus.req_ready = 1'b0;
            bus.mem_rd_en = 1'b0;
            bus.mem_wr_en = 1'b0;
            bus.mem_wdata = '0;
            bus.mem_addr  = '0;
            bus.done      = 1'b0;
            bus.err       = 1'b0;
        end
    end
endmodule

// File: tb/tb_store_merge_unit.sv
// tb_store_merge_unit: random and directed stores checked by a scoreboard against a byte-lane memory model
module tb_store_merge_unit;
    logic Clk = 1'b0;
    logic Reset = 1'b1;
    always #5 Clk = ~Clk;

    store_merge_unit_if #(.ADDR_WIDTH(32)) bus ();
    store_merge_unit #(.ADDR_WIDTH(32)) dut (.Clk(Clk), .Reset(Reset), .bus(bus));

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  op;
        int          acc;
    } req_t;

    req_t        sb[$];
    logic [31:0] mem[64];
    logic [31:0] ref_mem[64];
    int          compared = 0;
    int          mismatched = 0;
    int          cyc = 0;
    bit          busy = 1'b0;
    int          reads = 0;
    req_t        r;
    logic [31:0] e;
    bit          f;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit is_fault(req_t q);
`ifdef STORE_MISALIGN_CHECK_EN
        return q.op == 2'b11 || (q.op == 2'b00 && q.addr[0]);
`else
        return q.op == 2'b11;
`endif
    endfunction

    function automatic logic [31:0] model(req_t q, logic [31:0] old);
        logic [7:0] b[4];
        if (q.op == 2'b10) return q.data;
        for (int i = 0; i < 4; i++) b[i] = old[8*i +: 8];
        if (q.op == 2'b01) begin
            b[q.addr[1:0]] = q.data[7:0];
        end else begin
            b[{q.addr[1], 1'b0}] = q.data[7:0];
            b[{q.addr[1], 1'b1}] = q.data[15:8];
        end
        return {b[3], b[2], b[1], b[0]};
    endfunction

    always @(posedge Clk) cyc <= cyc + 1;

    always @(posedge Clk) begin
        bus.mem_rdata <= bus.mem_rd_en ? mem[bus.mem_addr[7:2]] : $urandom;
        if (bus.mem_wr_en) mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
    end

    always @(negedge Clk) begin
        if (Reset) begin
            check("reset_outputs", {27'b0, bus.req_ready, bus.mem_rd_en, bus.mem_wr_en, bus.done, bus.err} | bus.mem_addr | bus.mem_wdata, 32'h0);
            sb.delete();
            busy = 1'b0;
            reads = 0;
        end else begin
            check("ready", bus.req_ready, !busy);
            if (bus.mem_rd_en || bus.mem_wr_en) check("rd_wr_exclusive", bus.mem_rd_en & bus.mem_wr_en, 0);
            if (bus.mem_rd_en) begin
                reads++;
                if (sb.size() == 0) check("rd_unexpected", 1, 0);
                else check("rd_addr", bus.mem_addr, {sb[0].addr[31:2], 2'b00});
            end
            if (bus.mem_wr_en && !bus.done) check("wr_without_done", 1, 0);
            if (bus.err && !bus.done) check("err_without_done", 1, 0);
            if (bus.done) begin
                if (sb.size() == 0) begin
                    check("done_unexpected", 1, 0);
                end else begin
                    r = sb.pop_front();
                    f = is_fault(r);
                    check("err", bus.err, f);
                    check("wr_en", bus.mem_wr_en, !f);
                    check("latency", cyc - r.acc, (f || r.op == 2'b10) ? 1 : 3);
                    check("read_count", reads, (!f && r.op != 2'b10) ? 1 : 0);
                    if (!f) begin
                        e = model(r, ref_mem[r.addr[7:2]]);
                        check("wr_addr", bus.mem_addr, {r.addr[31:2], 2'b00});
                        check("wdata", bus.mem_wdata, e);
                        ref_mem[r.addr[7:2]] = e;
                    end
                end
                busy = 1'b0;
                reads = 0;
            end
            if (bus.req_ready && bus.req_valid) busy = 1'b1;
        end
    end

    task automatic issue(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] op, output int acc);
        int w = 0;
        bus.req_valid = 1'b1;
        bus.req_addr  = addr;
        bus.req_data  = data;
        bus.StoreOp   = op;
        acc = -1;
        while (!bus.req_ready) begin
            @(posedge Clk); #2;
            if (++w > 50) begin
                compared++; mismatched++;
                $display("FAIL accept_timeout: req_ready low for %0d cycles, required high", w);
                bus.req_valid = 1'b0;
                return;
            end
        end
        acc = cyc;
        sb.push_back('{addr, data, op, cyc});
        @(posedge Clk); #2;
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int w = 0;
        while (sb.size() != 0 && w < 50) begin
            @(posedge Clk); #2;
            w++;
        end
        if (w >= 50) begin
            compared++; mismatched++;
            $display("FAIL done_timeout: %0d stores still pending, required 0", sb.size());
        end
        @(posedge Clk); #2;
    endtask

    task automatic set_word(input int idx, input logic [31:0] v);
        mem[idx] <= v;
        ref_mem[idx] = v;
    endtask

    initial begin
        int a1, a2;
        logic [31:0] v;
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.req_data  = '0;
        bus.StoreOp   = 2'b00;
        for (int i = 0; i < 64; i++) begin
            v = $urandom;
            mem[i] <= v;
            ref_mem[i] = v;
        end
        repeat (3) @(posedge Clk);
        #2 Reset = 1'b0;
        @(posedge Clk); #2;

        set_word(4, 32'h1122_3344);
        issue(32'h13, 32'hAB, 2'b01, a1);
        wait_idle();
        check("byte_store_mem", mem[4], 32'hAB22_3344);

        set_word(8, 32'hCAFE_F00D);
        issue(32'h22, 32'hBEEF, 2'b00, a1);
        wait_idle();
        check("half_store_mem", mem[8], 32'hBEEF_F00D);

        issue(32'h40, 32'hDEAD_BEEF, 2'b10, a1);
        wait_idle();
        check("word_store_mem", mem[16], 32'hDEAD_BEEF);

        issue(32'h10, 32'h55, 2'b01, a1);
        issue(32'h44, 32'h0BAD_F00D, 2'b10, a2);
        check("b2b_accept_gap", a2 - a1, 4);
        wait_idle();
        check("b2b_byte_mem", mem[4][7:0], 32'h55);
        check("b2b_word_mem", mem[17], 32'h0BAD_F00D);

        issue(32'h0000_0FFD, 32'h1234_5678, 2'b11, a1);
        wait_idle();

        set_word(8, 32'hCAFE_F00D);
        issue(32'h21, 32'h1234, 2'b00, a1);
        wait_idle();
`ifdef STORE_MISALIGN_CHECK_EN
        check("misaligned_half_mem", mem[8], 32'hCAFE_F00D);
`else
        check("misaligned_half_mem", mem[8], 32'hCAFE_1234);
`endif

        set_word(4, 32'h7788_99AA);
        issue(32'h10, 32'h99, 2'b01, a1);
        @(posedge Clk); #2;
        Reset = 1'b1;
        repeat (2) @(posedge Clk);
        #2 Reset = 1'b0;
        @(posedge Clk); #2;
        check("reset_no_write", mem[4], 32'h7788_99AA);

        for (int n = 0; n < 150; n++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge Clk); #2;
            end
            issue($urandom, $urandom, 2'($urandom_range(0, 3)), a1);
        end
        wait_idle();
        for (int i = 0; i < 64; i++) check("mem_final", mem[i], ref_mem[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/store_merge_unit.md
# store_merge_unit

Write-side counterpart of the load decode path: it takes a byte, halfword or word store from the datapath and turns it into a full 32-bit write to a word-wide data memory with no byte enables. Sub-word stores run a read-modify-write sequence (read word, merge lanes, write word); word stores are written directly. It sits between the MEM-stage store request and the data memory port, and the pipeline stalls on `req_ready`.

## Interface
- `ADDR_WIDTH`, 32: byte address width.
- `Clk`  in  1  single clock; all state updates on rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  store request present.
- `req_ready`  out  1  block can accept a request (IDLE only).
- `req_addr`  in  ADDR_WIDTH  byte address of the store.
- `req_data`  in  32  store data; the byte is in [7:0], the halfword in [15:0].
- `StoreOp`  in  2  size: 00 halfword, 01 byte, 10 word, 11 reserved.
- `mem_addr`  out  ADDR_WIDTH  word-aligned address, with [1:0] always 00.
- `mem_rd_en`  out  1  read strobe; `mem_rdata` is valid exactly 1 cycle later.
- `mem_rdata`  in  32  memory read data.
- `mem_wr_en`  out  1  write strobe, 1 cycle.
- `mem_wdata`  out  32  merged write word.
- `done`  out  1  1-cycle pulse when the store completes or is dropped.
- `err`  out  1  1-cycle pulse together with `done` when the request was dropped.

## Operation
- FSM states: IDLE, READ, MERGE, WRITE, FAULT.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`, the request is accepted and `req_addr`, `req_data` and `StoreOp` are latched.
  - Next state by `StoreOp`: 10 goes to WRITE; 00 and 01 go to READ; 11 goes to FAULT.
- READ: `mem_rd_en`=1, `mem_addr`={addr[ADDR_WIDTH-1:2],2'b00}. Next state MERGE.
- MERGE: capture `mem_rdata` and build the merged word in a register. Lanes are little-endian:
  - Byte: lane k=addr[1:0] gets bits [8k+7:8k] = data[7:0]; the other bytes keep their old value.
  - Halfword: h=addr[1] gets bits [16h+15:16h] = data[15:0]. addr[0] is ignored unless the misalign check is enabled (see Configuration).
  - Next state WRITE.
- WRITE: `mem_wr_en`=1, `done`=1, `mem_wdata` = merged word (word store: latched data unmodified). Next state IDLE.
- FAULT: `done`=1, `err`=1. No memory access. Next state IDLE.
- `mem_addr` holds the latched word address from acceptance until the block returns to IDLE. It is 0 in IDLE.
- Only one request is in flight. `req_valid` outside IDLE is ignored; the request stays pending upstream.

## Timing
- Cycle 0 is the acceptance edge.
- Word store:
  - `mem_wr_en`/`done` in cycle 1.
  - `req_ready` returns in cycle 2.
- Sub-word store:
  - `mem_rd_en` in cycle 1.
  - `mem_rdata` is sampled in cycle 2.
  - `mem_wr_en`/`done` in cycle 3.
  - `req_ready` returns in cycle 4.
- Reserved op: `done`/`err` in cycle 1.
- Back-to-back requests: a new request can be accepted in the first IDLE cycle after `done`. There are no bubbles beyond that.
- `mem_rd_en` and `mem_wr_en` are never asserted in the same cycle.
- Reset:
  - While `Reset`=1: state is IDLE, all outputs are 0, including `req_ready`. Latched request registers are cleared to 0.
  - `req_ready`=1 in the first cycle after `Reset` deasserts.
- Reset mid-operation (READ, MERGE or WRITE): the request is discarded. No `mem_wr_en` is asserted in the reset cycle or afterwards for that request, and no `done` is produced.

## Configuration
- `STORE_MISALIGN_CHECK_EN` defined: a halfword store with addr[0]=1 goes from IDLE to FAULT. It produces `done`+`err` in cycle 1, with no read and no write.
- Not defined: addr[0] is ignored for halfwords, and the store is aligned down to lane addr[1]. `err` is asserted only for `StoreOp`=11.

## Test plan
- Byte store: addr 0x00000013, data 0x000000AB, `StoreOp`=01, memory word at 0x10 = 0x11223344. Required response: read at 0x10 in cycle 1; write of 0xAB223344 to 0x10 in cycle 3; `done` in cycle 3; `err`=0.
- Halfword store: addr 0x00000022, data 0x0000BEEF, `StoreOp`=00, memory word = 0xCAFEF00D. Required response: write of 0xBEEFF00D to 0x20 in cycle 3.
- Word store: addr 0x00000040, data 0xDEADBEEF, `StoreOp`=10. Required response: no `mem_rd_en`; write of 0xDEADBEEF to 0x40 in cycle 1; `req_ready` high in cycle 2.
- Back-to-back: a byte store to 0x10 lane 0 with data 0x55, followed by a word store held on `req_valid`. Required response: the second request is accepted in cycle 4 and written in cycle 5. `req_ready` is 0 in cycles 1–3.
- Reset in MERGE: assert `Reset` in cycle 2 of a byte store. Required response: `mem_wr_en` and `done` never assert; all outputs are 0 during reset; `req_ready`=1 on the cycle after release.
- Fault cases:
  - `StoreOp`=11, any address: `done`=`err`=1 in cycle 1, with no memory strobes.
  - With `STORE_MISALIGN_CHECK_EN`, a halfword store at 0x21: same fault response.
  - Without the macro, the same halfword store at 0x21 writes lane 0 of 0x20.
